// File: rtl/sigdata_gen.sv
// sigdata_gen: burst stimulus source for the parallel-data path.
// Each ask_for_data rising edge yields BURST words after DELAY cycles.
//
// Ports:
//   sclk         - clock, rising edge
//   rst          - synchronous reset, active-high
//   ask_for_data - request level, rising edge = one request
//   mode         - 00 counter, 01 LFSR, 10 walking one, 11 constant
//   cfg_pattern  - word emitted in mode 11
//   data         - current word, holds while data_valid=0
//   data_valid   - high for each word of a burst
//   busy         - high from T0+1 until the last word
//   req_dropped  - high in the cycle a request is ignored
//
// Optional: define REQ_QUEUE_EN for a one-deep pending request.

module sigdata_gen #(
  parameter int unsigned       DATA_W = 4,
  parameter int unsigned       DELAY  = 3,
  parameter int unsigned       BURST  = 1,
  parameter logic [DATA_W-1:0] POLY   = 'h9,
  parameter logic [DATA_W-1:0] SEED   = 'h1
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              ask_for_data,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] cfg_pattern,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              busy,
  output logic              req_dropped
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND
  } state_t;

  localparam logic [7:0] DLY   = 8'(DELAY);
  localparam logic [7:0] BLAST = 8'(BURST - 1);
  localparam bit         DLY0  = (DELAY == 0);

  state_t            state_q;
  logic              ask_q;
  logic [1:0]        mode_q;
  logic [7:0]        wcnt_q;
  logic [7:0]        bcnt_q;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] lfsr_q, lfsr_d, lfsr_cur;
  logic [DATA_W-1:0] walk_q, walk_d;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              busy_q;

  logic              req;
  logic              drop;
  logic              restart;
  logic              fire;
  logic [1:0]        emit_mode;
  logic [DATA_W-1:0] word;

`ifdef REQ_QUEUE_EN
  logic       pend_q;
  logic [1:0] pmode_q;
  logic       take;
  logic [1:0] pmode_now;
`endif

  assign req = ask_for_data & ~ask_q;

  // busy_q is low only in IDLE, so it alone decides drop vs accept
  always_comb begin
`ifdef REQ_QUEUE_EN
    take      = req & busy_q & ~pend_q;
    drop      = req & busy_q & pend_q;
    pmode_now = pend_q ? pmode_q : mode;
    // a request captured in the final SEND cycle still chains on
    restart   = (state_q == SEND) & (bcnt_q == 8'd0)
              & (pend_q | take);
`else
    drop      = req & busy_q;
    restart   = 1'b0;
`endif
  end

  assign req_dropped = drop & ~rst;

  // fire: a word is registered onto data at this edge
  always_comb begin
    fire = 1'b0;
    unique case (state_q)
      IDLE:    fire = req & DLY0;
      WAIT:    fire = (wcnt_q == 8'd1);
      SEND:    fire = (bcnt_q != 8'd0) | (restart & DLY0);
      default: fire = 1'b0;
    endcase
  end

  // first word with DELAY=0 uses the mode being accepted now
  always_comb begin
    emit_mode = mode_q;
    if (state_q == IDLE) emit_mode = mode;
`ifdef REQ_QUEUE_EN
    if (restart) emit_mode = pmode_now;
`endif
  end

  // zero state would lock the LFSR, so it is treated as SEED
  assign lfsr_cur = (lfsr_q == '0) ? SEED : lfsr_q;

  always_comb begin
    cnt_d  = cnt_q;
    lfsr_d = lfsr_q;
    walk_d = walk_q;
    word   = cnt_q;
    unique case (emit_mode)
      2'b00: begin
        word = cnt_q;
        if (fire) cnt_d = cnt_q + 1'b1;
      end
      2'b01: begin
        word = lfsr_cur;
        if (fire)
          lfsr_d = (lfsr_cur >> 1)
                 ^ (lfsr_cur[0] ? POLY : '0);
      end
      2'b10: begin
        word = walk_q;
        if (fire)
          walk_d = {walk_q[DATA_W-2:0],
                    walk_q[DATA_W-1]};
      end
      2'b11: word = cfg_pattern;
      default: word = cnt_q;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= IDLE;
      ask_q   <= 1'b0;
      mode_q  <= 2'b00;
      wcnt_q  <= 8'd0;
      bcnt_q  <= 8'd0;
      cnt_q   <= '0;
      lfsr_q  <= SEED;
      walk_q  <= DATA_W'(1);
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef REQ_QUEUE_EN
      pend_q  <= 1'b0;
      pmode_q <= 2'b00;
`endif
    end else begin
      ask_q   <= ask_for_data;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      walk_q  <= walk_d;
      valid_q <= fire;
      if (fire) data_q <= word;
`ifdef REQ_QUEUE_EN
      if (restart) begin
        pend_q <= 1'b0;
      end else if (take) begin
        pend_q  <= 1'b1;
        pmode_q <= mode;
      end
`endif
      unique case (state_q)
        IDLE: begin
          if (req) begin
            mode_q  <= mode;
            busy_q  <= 1'b1;
            wcnt_q  <= DLY;
            bcnt_q  <= BLAST;
            state_q <= DLY0 ? SEND : WAIT;
          end
        end
        WAIT: begin
          wcnt_q <= wcnt_q - 8'd1;
          if (wcnt_q == 8'd1) state_q <= SEND;
        end
        SEND: begin
          if (bcnt_q != 8'd0) begin
            bcnt_q <= bcnt_q - 8'd1;
          end else if (restart) begin
`ifdef REQ_QUEUE_EN
            mode_q <= pmode_now;
`endif
            wcnt_q  <= DLY;
            bcnt_q  <= BLAST;
            state_q <= DLY0 ? SEND : WAIT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sigdata_gen.sv
// tb_sigdata_gen: two sigdata_gen instances driven in parallel,
// checked every cycle against a window-based reference model.

module tb_sigdata_gen;

  localparam int DA = 3;
  localparam int BA = 2;
  localparam int DB = 0;
  localparam int BB = 5;

  logic       sclk = 1'b0;
  logic       rst  = 1'b1;
  logic       ask  = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] cfg  = 4'h0;

  logic [3:0] data_a, data_b;
  logic       va, vb, ba, bb, dra, drb;

  always #5 sclk = ~sclk;

  sigdata_gen #(
    .DATA_W(4), .DELAY(DA), .BURST(BA),
    .POLY(4'b1001), .SEED(4'd1)
  ) u_a (
    .sclk(sclk), .rst(rst), .ask_for_data(ask),
    .mode(mode), .cfg_pattern(cfg), .data(data_a),
    .data_valid(va), .busy(ba), .req_dropped(dra)
  );

  sigdata_gen #(
    .DATA_W(4), .DELAY(DB), .BURST(BB),
    .POLY(4'b1001), .SEED(4'd1)
  ) u_b (
    .sclk(sclk), .rst(rst), .ask_for_data(ask),
    .mode(mode), .cfg_pattern(cfg), .data(data_b),
    .data_valid(vb), .busy(bb), .req_dropped(drb)
  );

  int npass = 0;
  int ntot  = 0;
  int t     = 0;
  bit chk_en = 1'b0;

  int dly[2] = '{DA, DB};
  int bur[2] = '{BA, BB};

  // model: a burst is a window [wf,wl] of emit cycles,
  // busy is the window [bst,bend]
  bit askp;
  int wf[2], wl[2], wm[2], bst[2], bend[2];
  bit pend[2];
  int pm[2];
  int cnt[2], lf[2], wk[2];
  int e_data[2], e_valid[2], e_busy[2];

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    ntot++;
    assert (o === e) npass++;
    else $error("FAIL %s t=%0d got=%0h exp=%0h",
                tag, t, o, e);
  endtask

  function automatic void m_reset(int i);
    wf[i] = 0; wl[i] = -1;
    bst[i] = 0; bend[i] = -1;
    pend[i] = 1'b0; pm[i] = 0;
    cnt[i] = 0; lf[i] = 1; wk[i] = 0;
    e_data[i] = 0; e_valid[i] = 0; e_busy[i] = 0;
  endfunction

  function automatic bit m_busy(int i, int c);
    return (c >= bst[i]) && (c <= bend[i]);
  endfunction

  function automatic bit m_drop(int i, bit r);
`ifdef REQ_QUEUE_EN
    return r && m_busy(i, t) && pend[i];
`else
    return r && m_busy(i, t);
`endif
  endfunction

  function automatic int m_word(int i, int m, int c);
    int w;
    w = 0;
    case (m)
      0: begin w = cnt[i]; cnt[i] = (cnt[i] + 1) % 16; end
      1: begin
        if (lf[i] == 0) lf[i] = 1;
        w = lf[i];
        lf[i] = (lf[i] >> 1) ^ ((lf[i] % 2 == 1) ? 9 : 0);
      end
      2: begin w = 1 << wk[i]; wk[i] = (wk[i] + 1) % 4; end
      default: w = c;
    endcase
    return w;
  endfunction

  function automatic void m_step(int i, bit r);
    if (r && !m_busy(i, t)) begin
      bst[i]  = t + 1;
      bend[i] = t + dly[i] + bur[i];
      wf[i]   = t + dly[i] + 1;
      wl[i]   = bend[i];
      wm[i]   = mode;
    end else if (r) begin
`ifdef REQ_QUEUE_EN
      if (!pend[i]) begin
        pend[i] = 1'b1;
        pm[i]   = mode;
      end
`endif
    end
`ifdef REQ_QUEUE_EN
    if (pend[i] && t == bend[i]) begin
      pend[i] = 1'b0;
      bend[i] = t + dly[i] + bur[i];
      wf[i]   = t + dly[i] + 1;
      wl[i]   = bend[i];
      wm[i]   = pm[i];
    end
`endif
    e_valid[i] = (t + 1 >= wf[i]) && (t + 1 <= wl[i]);
    if (e_valid[i] != 0)
      e_data[i] = m_word(i, wm[i], int'(cfg));
    e_busy[i] = m_busy(i, t + 1);
  endfunction

  task automatic tick();
    bit r;
    @(negedge sclk);
    r = ask && !askp;
    if (chk_en) begin
      chk("a.data", data_a, e_data[0]);
      chk("a.valid", va, e_valid[0]);
      chk("a.busy", ba, e_busy[0]);
      chk("a.drop", dra, rst ? 0 : m_drop(0, r));
      chk("b.data", data_b, e_data[1]);
      chk("b.valid", vb, e_valid[1]);
      chk("b.busy", bb, e_busy[1]);
      chk("b.drop", drb, rst ? 0 : m_drop(1, r));
    end
    if (rst) begin
      askp = 1'b0;
      m_reset(0);
      m_reset(1);
    end else begin
      askp = ask;
      m_step(0, r);
      m_step(1, r);
    end
    t++;
    @(posedge sclk);
    #1;
  endtask

  task automatic pulse(input int m, input int gap);
    mode = 2'(m);
    ask  = 1'b1;
    tick();
    ask  = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    askp = 1'b0;
    m_reset(0);
    m_reset(1);
    #1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // counter: 0,1,2,3,4 then wrap
    repeat (5) pulse(0, 8);
    repeat (5) pulse(0, 7);

    // LFSR, walking one
    repeat (5) pulse(1, 8);
    repeat (3) pulse(2, 8);

    // constant, mode flipped mid-burst
    cfg  = 4'hA;
    mode = 2'b11;
    ask  = 1'b1;
    tick();
    ask  = 1'b0;
    tick();
    mode = 2'b00;
    repeat (8) tick();

    // second edge at T0+2 while busy
    mode = 2'b00;
    ask  = 1'b1;
    tick();
    ask  = 1'b0;
    tick();
    ask  = 1'b1;
    tick();
    ask  = 1'b0;
    repeat (12) tick();

    // request landing in the last SEND cycle of u_a
    ask = 1'b1;
    tick();
    ask = 1'b0;
    repeat (4) tick();
    ask = 1'b1;
    tick();
    ask = 1'b0;
    repeat (12) tick();

    // reset mid-burst, then ask held through release
    ask = 1'b1;
    tick();
    ask = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    ask = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    ask = 1'b0;
    repeat (10) tick();

    // random traffic
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 2) == 0) ask = ~ask;
      mode = 2'($urandom_range(0, 3));
      cfg  = 4'($urandom_range(0, 15));
      rst  = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;
    ask = 1'b0;
    repeat (12) tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
